parity_gen_tx: RTL
==================

Name: parity_gen_tx

Overview:
Serial even-parity transmitter.
- Accepts parallel words over a valid/ready handshake.
- Shifts each word out one bit per cycle, then appends one parity bit so that every frame has even weight (odd if configured).
- Acts as the transmit end of the serial parity link: a downstream even-parity checker sees "even" after every complete frame.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; legal range 1..32.
- LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit DATA_WIDTH-1 is sent first.
- ODD_PARITY, 0, 0 = frame has an even number of ones; 1 = frame has an odd number of ones.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-low; reset is asserted while rst = 0.
- dataIn  input  DATA_WIDTH  word to transmit; sampled on accept.
- dataValid  input  1  dataIn is valid.
- dataReady  output  1  block can accept a word this cycle.
- seqOut  output  1  serial bit (payload or parity).
- seqValid  output  1  seqOut carries a frame bit this cycle.
- frameEnd  output  1  current seqOut is the parity bit (last bit of the frame).

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE, shift register = 0, bit counter = 0, parity accumulator = 0, seqOut = 0, seqValid = 0, frameEnd = 0. dataReady is forced to 0 while rst = 0.
- Accept: a word is accepted when dataValid & dataReady are both 1 at a rising clk edge. Only then is dataIn sampled.
- dataReady decode (combinational from state): 1 in IDLE; 1 in PARITY (enables back-to-back frames); 0 in SHIFT.
- seqOut, seqValid and frameEnd are registered, so there is no combinational path from inputs to them.
- FSM states:
  - IDLE: seqValid = 0, seqOut = 0. On accept: load the shift register, clear the counter, set accumulator = ODD_PARITY, go to SHIFT.
  - SHIFT: each cycle presents the next payload bit with seqValid = 1 and XORs it into the accumulator. The counter runs 0..DATA_WIDTH-1. After bit DATA_WIDTH-1 is presented, go to PARITY.
  - PARITY: one cycle with seqOut = accumulated parity, seqValid = 1, frameEnd = 1.
    - If accepted in this cycle: reload and go to SHIFT, so the next bit 0 follows with no gap.
    - Otherwise: go to IDLE.
- Timing:
  - Latency: a word accepted at edge N has its first payload bit on seqOut from edge N+1.
  - The parity bit appears at edge N+DATA_WIDTH+1.
  - A frame occupies DATA_WIDTH+1 consecutive valid cycles.
  - Peak throughput is one word per DATA_WIDTH+1 cycles.
- Parity rule: parity bit = XOR of all payload bits, XOR ODD_PARITY. The XOR of all DATA_WIDTH+1 frame bits therefore equals ODD_PARITY.
- Counter width: clog2(DATA_WIDTH), minimum 1. The counter saturates at DATA_WIDTH-1 (no wrap inside SHIFT) and is cleared only on load.
- Boundary conditions:
  - dataValid while in SHIFT is ignored; dataIn is not sampled and nothing is lost from the upstream's view because dataReady = 0.
  - dataIn changing mid-frame has no effect.
  - DATA_WIDTH = 1: SHIFT lasts exactly one cycle.
  - Reset asserted mid-frame aborts immediately: outputs return to reset values, and no parity bit is emitted for the partial frame.
  - The first accept is possible on the first rising edge after rst returns to 1.

Decomposition:
- Shared package contents:
  - State enumeration, encoded IDLE = 0, SHIFT = 1, PARITY = 2 on 2 bits.
  - Default width constant PARITY_DATA_WIDTH = 8.
  - A parity-fold helper function (XOR reduce), also usable by checker-side blocks.
- Single module; no sub-module is warranted. The serializer and accumulator are a few registers each.

Test Plan:
- Even word, LSB_FIRST=1: dataIn = 0xA5, single accept → seqOut = 1,0,1,0,0,1,0,1 then parity 0 with frameEnd = 1. seqValid is high for exactly 9 cycles, and dataReady returns to 1 in the parity cycle.
- Odd weight: dataIn = 0x07 → payload 1,1,1,0,0,0,0,0 then parity 1. With ODD_PARITY=1 the same word gives parity 0.
- Back-to-back: dataValid held high with 0x01 then 0xFF → 18 contiguous valid cycles.
  - Parities are 1 then 0.
  - The second word is accepted in the first frame's PARITY cycle.
  - There is no idle cycle between frames.
- MSB first (LSB_FIRST=0): dataIn = 0x80 → bits 1,0,0,0,0,0,0,0, parity 1.
- Reset mid-frame: assert rst = 0 asynchronously after 3 payload bits of 0xFF → seqValid and seqOut drop to 0 before the next edge. After release, the first accept of 0x00 yields 8 zeros plus parity 0.
- Property, random words plus random dataValid gaps for 10k cycles:
  - The XOR of every frame equals ODD_PARITY.
  - seqValid gaps occur only in IDLE.
  - The number of accepts equals the number of frameEnd pulses.

Source files
------------

// File: rtl/parity_gen_tx_pkg.sv
// Shared types and helpers for the serial parity link (transmit and check sides).
package parity_gen_tx_pkg;

  localparam int PARITY_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } tx_state_e;

  // XOR-reduce of up to 32 bits; zero-extend narrower words before calling.
  function automatic logic parity_fold(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/parity_gen_tx.sv
// Serial parity transmitter: takes a word on valid/ready, shifts it out one bit
// per cycle and appends a parity bit so every frame has the configured weight.
module parity_gen_tx
  import parity_gen_tx_pkg::*;
#(
  parameter int DATA_WIDTH = PARITY_DATA_WIDTH,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  dataValid,
  output logic                  dataReady,
  output logic                  seqOut,
  output logic                  seqValid,
  output logic                  frameEnd
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q;
  logic                  acc_q;
  logic                  seq_q, sv_q, fe_q;
  logic                  nxt_bit;
  logic                  accept;

  // Ready is held low during reset so nothing can be accepted while aborting.
  assign dataReady = rst & ((state_q == ST_IDLE) | (state_q == ST_PARITY));
  assign accept    = dataValid & dataReady;

  assign nxt_bit = LSB_FIRST ? shift_q[0] : shift_q[DATA_WIDTH-1];

  always_comb begin
    shift_d = shift_q;
    if (LSB_FIRST) shift_d = shift_q >> 1;
    else           shift_d = shift_q << 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      seq_q   <= 1'b0;
      sv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          seq_q <= 1'b0;
          sv_q  <= 1'b0;
          fe_q  <= 1'b0;
          if (accept) begin
            shift_q <= dataIn;
            cnt_q   <= '0;
            acc_q   <= ODD_PARITY;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          seq_q   <= nxt_bit;
          sv_q    <= 1'b1;
          fe_q    <= 1'b0;
          shift_q <= shift_d;
          acc_q   <= acc_q ^ nxt_bit;
          // Counter parks on the last index; only a load clears it.
          if (cnt_q == CNT_LAST) state_q <= ST_PARITY;
          else                   cnt_q   <= cnt_q + CW'(1);
        end
        ST_PARITY: begin
          seq_q <= acc_q;
          sv_q  <= 1'b1;
          fe_q  <= 1'b1;
          if (accept) begin
            shift_q <= dataIn;
            cnt_q   <= '0;
            acc_q   <= ODD_PARITY;
            state_q <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign seqOut   = seq_q;
  assign seqValid = sv_q;
  assign frameEnd = fe_q;

endmodule
